// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: two result FIFOs (ALU, LSB) drained round-robin onto one registered CDB port.
// Optional macro CDB_BYPASS_EN lets an empty source's push go straight to the CDB when it wins the grant.
module cdb_arbiter #(
  parameter int ENTRY_W = 5,
  parameter int DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rdy_i,
  input  logic               rollback_i,
  input  logic               alu_valid_i,
  input  logic [ENTRY_W-1:0] alu_entry_i,
  input  logic [31:0]        alu_result_i,
  input  logic [31:0]        alu_pc_i,
  output logic               alu_full_o,
  input  logic               lsb_valid_i,
  input  logic [ENTRY_W-1:0] lsb_entry_i,
  input  logic [31:0]        lsb_result_i,
  output logic               lsb_full_o,
  output logic               cdb_valid_o,
  output logic               cdb_src_o,
  output logic [ENTRY_W-1:0] cdb_entry_o,
  output logic [31:0]        cdb_result_o,
  output logic [31:0]        cdb_pc_o,
  output logic               overflow_err_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_LSB = 1'b1;

  logic [ENTRY_W-1:0] alu_entry_mem [DEPTH];
  logic [31:0]        alu_result_mem [DEPTH];
  logic [31:0]        alu_pc_mem [DEPTH];
  logic [ENTRY_W-1:0] lsb_entry_mem [DEPTH];
  logic [31:0]        lsb_result_mem [DEPTH];

  logic [PW-1:0] alu_rptr_q, alu_wptr_q, lsb_rptr_q, lsb_wptr_q;
  logic [CW-1:0] alu_cnt_q, lsb_cnt_q, alu_cnt_d, lsb_cnt_d;
  logic          last_grant_q;
  logic          cdb_valid_q, cdb_src_q, ovf_q;
  logic [ENTRY_W-1:0] cdb_entry_q;
  logic [31:0]   cdb_result_q, cdb_pc_q;

  logic act, alu_byp, lsb_byp, alu_elig, lsb_elig, grant_alu, grant_lsb;
  logic alu_push, alu_pop, lsb_push, lsb_pop, drop;
  logic [ENTRY_W-1:0] alu_head_entry, lsb_head_entry;
  logic [31:0] alu_head_result, alu_head_pc, lsb_head_result;

  assign alu_full_o     = (alu_cnt_q == FULL_CNT);
  assign lsb_full_o     = (lsb_cnt_q == FULL_CNT);
  assign cdb_valid_o    = cdb_valid_q;
  assign cdb_src_o      = cdb_src_q;
  assign cdb_entry_o    = cdb_entry_q;
  assign cdb_result_o   = cdb_result_q;
  assign cdb_pc_o       = cdb_pc_q;
  assign overflow_err_o = ovf_q;

  always_comb begin
    act = rdy_i && !rollback_i;
`ifdef CDB_BYPASS_EN
    alu_byp         = (alu_cnt_q == '0) && alu_valid_i;
    lsb_byp         = (lsb_cnt_q == '0) && lsb_valid_i;
    alu_head_entry  = alu_byp ? alu_entry_i  : alu_entry_mem[alu_rptr_q];
    alu_head_result = alu_byp ? alu_result_i : alu_result_mem[alu_rptr_q];
    alu_head_pc     = alu_byp ? alu_pc_i     : alu_pc_mem[alu_rptr_q];
    lsb_head_entry  = lsb_byp ? lsb_entry_i  : lsb_entry_mem[lsb_rptr_q];
    lsb_head_result = lsb_byp ? lsb_result_i : lsb_result_mem[lsb_rptr_q];
`else
    alu_byp         = 1'b0;
    lsb_byp         = 1'b0;
    alu_head_entry  = alu_entry_mem[alu_rptr_q];
    alu_head_result = alu_result_mem[alu_rptr_q];
    alu_head_pc     = alu_pc_mem[alu_rptr_q];
    lsb_head_entry  = lsb_entry_mem[lsb_rptr_q];
    lsb_head_result = lsb_result_mem[lsb_rptr_q];
`endif
    alu_elig  = (alu_cnt_q != '0) || alu_byp;
    lsb_elig  = (lsb_cnt_q != '0) || lsb_byp;
    // On a tie the source opposite the previous grant wins.
    grant_alu = alu_elig && (!lsb_elig || last_grant_q == SRC_LSB);
    grant_lsb = lsb_elig && !grant_alu;
    alu_pop   = act && grant_alu && (alu_cnt_q != '0);
    lsb_pop   = act && grant_lsb && (lsb_cnt_q != '0);
    // Fullness uses the pre-edge count, so a same-cycle pop never makes room.
    alu_push  = act && alu_valid_i && !alu_full_o && !(grant_alu && alu_byp);
    lsb_push  = act && lsb_valid_i && !lsb_full_o && !(grant_lsb && lsb_byp);
    drop      = act && ((alu_valid_i && alu_full_o) || (lsb_valid_i && lsb_full_o));
    alu_cnt_d = alu_cnt_q;
    case ({alu_push, alu_pop})
      2'b10:   alu_cnt_d = alu_cnt_q + CW'(1);
      2'b01:   alu_cnt_d = alu_cnt_q - CW'(1);
      default: alu_cnt_d = alu_cnt_q;
    endcase
    lsb_cnt_d = lsb_cnt_q;
    case ({lsb_push, lsb_pop})
      2'b10:   lsb_cnt_d = lsb_cnt_q + CW'(1);
      2'b01:   lsb_cnt_d = lsb_cnt_q - CW'(1);
      default: lsb_cnt_d = lsb_cnt_q;
    endcase
  end

  // Payload storage needs no reset; validity lives in the counts.
  always_ff @(posedge clk) begin
    if (alu_push) begin
      alu_entry_mem[alu_wptr_q]  <= alu_entry_i;
      alu_result_mem[alu_wptr_q] <= alu_result_i;
      alu_pc_mem[alu_wptr_q]     <= alu_pc_i;
    end
    if (lsb_push) begin
      lsb_entry_mem[lsb_wptr_q]  <= lsb_entry_i;
      lsb_result_mem[lsb_wptr_q] <= lsb_result_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_rptr_q <= '0; alu_wptr_q <= '0; alu_cnt_q <= '0;
      lsb_rptr_q <= '0; lsb_wptr_q <= '0; lsb_cnt_q <= '0;
      last_grant_q <= SRC_LSB;
      cdb_valid_q  <= 1'b0;
      cdb_src_q    <= SRC_ALU;
      cdb_entry_q  <= '0;
      cdb_result_q <= '0;
      cdb_pc_q     <= '0;
      ovf_q        <= 1'b0;
    end else if (rollback_i) begin
      alu_rptr_q <= '0; alu_wptr_q <= '0; alu_cnt_q <= '0;
      lsb_rptr_q <= '0; lsb_wptr_q <= '0; lsb_cnt_q <= '0;
      last_grant_q <= SRC_LSB;
      cdb_valid_q  <= 1'b0;
    end else if (rdy_i) begin
      alu_cnt_q <= alu_cnt_d;
      lsb_cnt_q <= lsb_cnt_d;
      if (alu_push) alu_wptr_q <= alu_wptr_q + PW'(1);
      if (lsb_push) lsb_wptr_q <= lsb_wptr_q + PW'(1);
      if (alu_pop)  alu_rptr_q <= alu_rptr_q + PW'(1);
      if (lsb_pop)  lsb_rptr_q <= lsb_rptr_q + PW'(1);
      if (drop)     ovf_q <= 1'b1;
      cdb_valid_q <= grant_alu || grant_lsb;
      if (grant_alu) begin
        last_grant_q <= SRC_ALU;
        cdb_src_q    <= SRC_ALU;
        cdb_entry_q  <= alu_head_entry;
        cdb_result_q <= alu_head_result;
        cdb_pc_q     <= alu_head_pc;
      end else if (grant_lsb) begin
        last_grant_q <= SRC_LSB;
        cdb_src_q    <= SRC_LSB;
        cdb_entry_q  <= lsb_head_entry;
        cdb_result_q <= lsb_head_result;
        cdb_pc_q     <= '0;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus random traffic against a queue-based reference model.
module tb_cdb_arbiter;
  localparam int ENTRY_W = 5;
  localparam int DEPTH   = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rdy = 1'b0, rollback = 1'b0;
  logic alu_valid = 1'b0, lsb_valid = 1'b0;
  logic [ENTRY_W-1:0] alu_entry = '0, lsb_entry = '0;
  logic [31:0] alu_result = '0, alu_pc = '0, lsb_result = '0;
  logic alu_full, lsb_full, cdb_valid, cdb_src, overflow_err;
  logic [ENTRY_W-1:0] cdb_entry;
  logic [31:0] cdb_result, cdb_pc;

  cdb_arbiter #(.ENTRY_W(ENTRY_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .rdy_i(rdy), .rollback_i(rollback),
    .alu_valid_i(alu_valid), .alu_entry_i(alu_entry), .alu_result_i(alu_result),
    .alu_pc_i(alu_pc), .alu_full_o(alu_full),
    .lsb_valid_i(lsb_valid), .lsb_entry_i(lsb_entry), .lsb_result_i(lsb_result),
    .lsb_full_o(lsb_full),
    .cdb_valid_o(cdb_valid), .cdb_src_o(cdb_src), .cdb_entry_o(cdb_entry),
    .cdb_result_o(cdb_result), .cdb_pc_o(cdb_pc), .overflow_err_o(overflow_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ENTRY_W-1:0] e;
    logic [31:0]        r;
    logic [31:0]        p;
  } item_t;

  item_t qa[$], ql[$];
  bit    m_last_lsb, m_valid, m_src, m_ovf;
  logic [ENTRY_W-1:0] m_entry;
  logic [31:0] m_result, m_pc;
  int errors = 0, checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    qa.delete(); ql.delete();
    m_last_lsb = 1; m_valid = 0; m_src = 0; m_entry = '0; m_result = '0; m_pc = '0; m_ovf = 0;
  endtask

  // One clock edge of the arbiter described in terms of queues and the round-robin rule.
  task automatic model_step();
    int na, nl;
    bit ea, el, ga, gl, ba, bl, a_used, l_used;
    item_t it;
    if (rollback) begin
      qa.delete(); ql.delete(); m_valid = 0; m_last_lsb = 1;
      return;
    end
    if (!rdy) return;
    na = qa.size(); nl = ql.size();
    ba = 0; bl = 0;
`ifdef CDB_BYPASS_EN
    ba = (na == 0) && alu_valid;
    bl = (nl == 0) && lsb_valid;
`endif
    ea = (na > 0) || ba;
    el = (nl > 0) || bl;
    ga = (ea && el) ? m_last_lsb : ea;
    gl = el && !ga;
    a_used = 0; l_used = 0;
    if (ga) begin
      if (na > 0) it = qa.pop_front();
      else begin it = '{alu_entry, alu_result, alu_pc}; a_used = 1; end
      m_valid = 1; m_src = 0; m_entry = it.e; m_result = it.r; m_pc = it.p; m_last_lsb = 0;
    end else if (gl) begin
      if (nl > 0) it = ql.pop_front();
      else begin it = '{lsb_entry, lsb_result, 32'h0}; l_used = 1; end
      m_valid = 1; m_src = 1; m_entry = it.e; m_result = it.r; m_pc = 0; m_last_lsb = 1;
    end else m_valid = 0;
    if (alu_valid && !a_used) begin
      if (na < DEPTH) qa.push_back('{alu_entry, alu_result, alu_pc});
      else m_ovf = 1;
    end
    if (lsb_valid && !l_used) begin
      if (nl < DEPTH) ql.push_back('{lsb_entry, lsb_result, 32'h0});
      else m_ovf = 1;
    end
  endtask

  task automatic check_all();
    chk("cdb_valid", cdb_valid, m_valid);
    chk("cdb_src", cdb_src, m_src);
    chk("cdb_entry", cdb_entry, m_entry);
    chk("cdb_result", cdb_result, m_result);
    chk("cdb_pc", cdb_pc, m_pc);
    chk("alu_full", alu_full, qa.size() == DEPTH);
    chk("lsb_full", lsb_full, ql.size() == DEPTH);
    chk("overflow_err", overflow_err, m_ovf);
  endtask

  task automatic cycle(input bit r, input bit rb,
                       input bit av, input logic [ENTRY_W-1:0] ae, input logic [31:0] ar, input logic [31:0] ap,
                       input bit lv, input logic [ENTRY_W-1:0] le, input logic [31:0] lr);
    rdy = r; rollback = rb;
    alu_valid = av; alu_entry = ae; alu_result = ar; alu_pc = ap;
    lsb_valid = lv; lsb_entry = le; lsb_result = lr;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1, 0, 0, '0, 0, 0, 0, '0, 0);
  endtask

  initial begin
    model_reset();
    #12;
    check_all();
    rst_n = 1'b1;

    // Single ALU result.
    cycle(1, 0, 1, 5'd3, 32'h11, 32'h100, 0, '0, 0);
    idle(4);

    // Both sources push three beats: expect 1,4,2,5,3,6.
    for (int i = 0; i < 3; i++)
      cycle(1, 0, 1, ENTRY_W'(i + 1), 32'hA0 + i, 32'h200 + 4 * i, 1, ENTRY_W'(i + 4), 32'hB0 + i);
    idle(8);

    // Sustained dual pushes fill both FIFOs and drop results.
    for (int i = 0; i < 14; i++)
      cycle(1, 0, 1, ENTRY_W'(i), 32'hC00 + i, 32'h300 + i, 1, ENTRY_W'(i + 16), 32'hD00 + i);
    chk("ovf_set", overflow_err, 1);
    idle(12);
    chk("ovf_sticky", overflow_err, 1);

    // Queue three, then rollback with a simultaneous push.
    cycle(1, 0, 1, 5'd9, 32'h9, 32'h90, 1, 5'd10, 32'hA);
    cycle(1, 0, 1, 5'd11, 32'hB, 32'h94, 0, '0, 0);
    cycle(1, 1, 1, 5'd12, 32'hC, 32'h98, 1, 5'd13, 32'hD);
    chk("rollback_valid", cdb_valid, 0);
    idle(4);

    // Freeze with entry 7 on the bus; pushes while rdy is low are ignored.
    cycle(1, 0, 1, 5'd7, 32'h77, 32'h700, 0, '0, 0);
    cycle(1, 0, 0, '0, 0, 0, 0, '0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 1, 5'd20 + ENTRY_W'(i), 32'hEE, 32'hEE, 1, 5'd24, 32'hFF);
      chk("frozen_entry", cdb_entry, 7);
    end
    idle(4);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      cycle(($urandom_range(0, 9) < 8), ($urandom_range(0, 49) == 0),
            ($urandom_range(0, 9) < 6), ENTRY_W'($urandom), $urandom, $urandom,
            ($urandom_range(0, 9) < 6), ENTRY_W'($urandom), $urandom);
    idle(10);

    // Async reset mid-burst, then a tie must go to the ALU first.
    for (int i = 0; i < 4; i++)
      cycle(1, 0, 1, ENTRY_W'(i + 2), 32'h500 + i, 32'h600 + i, 1, ENTRY_W'(i + 8), 32'h700 + i);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    #3 rst_n = 1'b1;
    cycle(1, 0, 1, 5'd1, 32'h1, 32'h10, 1, 5'd2, 32'h2);
    cycle(1, 0, 1, 5'd3, 32'h3, 32'h30, 1, 5'd4, 32'h4);
    idle(3);
    cycle(1, 0, 1, 5'd5, 32'h5, 32'h50, 1, 5'd6, 32'h6);
    idle(1);
    chk("post_reset_tie_src", cdb_src, 0);
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
